// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: float field layout, IEEE encodings and the
// divider FSM state type.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_t;

  localparam int unsigned BIAS    = 127;
  localparam logic [7:0]  EXP_INF = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    NR,
    MUL,
    NORM,
    DONE
  } fdiv_state_t;

  // Signed infinity and signed zero encodings.
  function automatic logic [31:0] pack_inf(input logic s);
    return {s, EXP_INF, 23'd0};
  endfunction

  function automatic logic [31:0] pack_zero(input logic s);
    return {s, 31'd0};
  endfunction

endpackage

// File: rtl/fdiv_seed_rom.sv
// Reciprocal seed table for the iterative divider. Entry i holds the reciprocal
// of the midpoint of mantissa interval i, as a 10-bit fraction (value = entry/1024).
module fdiv_seed_rom #(
  parameter int unsigned SEED_BITS = 8
) (
  input  logic [SEED_BITS-1:0] idx,
  output logic [9:0]           seed
);

  // Midpoint m = (2^(S+1) + 2i + 1) / 2^(S+1); entry = round(1024 / m).
  function automatic logic [9:0] seed_val(input int unsigned i);
    int unsigned den;
    int unsigned num;
    int unsigned v;
    den = (32'd1 << (SEED_BITS + 1)) + 2 * i + 1;
    num = 32'd1 << (SEED_BITS + 11);
    v   = (num + den / 2) / den;
    return v[9:0];
  endfunction

  logic [9:0] rom [2**SEED_BITS];

  // Table contents are constants fixed at elaboration.
  for (genvar i = 0; i < 2**SEED_BITS; i++) begin : g_rom
    assign rom[i] = seed_val(i);
  end

  assign seed = rom[idx];

endmodule

// File: rtl/fdiv_iter.sv
// Multi-cycle single-precision divider y = x1 / x2 using a table seed refined by
// Newton-Raphson on one shared 32x32 multiplier, all arithmetic in Q2.30.
// Optional macro FDIV_IEEE_SPECIAL_EN decodes NaN/infinity operands.
module fdiv_iter
  import fpu_pkg::*;
#(
  parameter int unsigned NR_ITER   = 2,
  parameter int unsigned SEED_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] y,
  output logic        ovf,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int unsigned NrCyc = 2 * NR_ITER;
  localparam int unsigned CntW  = (NrCyc > 2) ? $clog2(NrCyc) : 1;
  localparam logic [31:0] TwoQ  = 32'h8000_0000;  // 2.0 in Q2.30

  fdiv_state_t state_q, state_d;
  float_t      f1, f2;
  logic        accept;

  logic            sign_q;
  logic [7:0]      e1_q, e2_q;
  logic [23:0]     m1_q, m2_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     r_q, t_q, q_q;
  logic [31:0]     y_q;
  logic            ovf_q, valid_q;

  logic [9:0]  seed;
  logic [31:0] mul_a, mul_b, prod_q30;
  logic [63:0] prod;

  logic               shift, rbit, carry;
  logic [23:0]        mant_pre, mant;
  logic [24:0]        mant_rnd;
  logic signed [9:0]  e_res;
  logic [31:0]        res_y, spec_y;
  logic               res_ovf, spec_ovf, spec_hit;
  logic               unused_bits;

  assign f1      = x1;
  assign f2      = x2;
  assign ready_o = (state_q == IDLE);
  assign accept  = valid_i && ready_o;
  assign y       = y_q;
  assign ovf     = ovf_q;
  assign valid_o = valid_q;

  fdiv_seed_rom #(
    .SEED_BITS(SEED_BITS)
  ) u_seed_rom (
    .idx  (m2_q[22 -: SEED_BITS]),
    .seed (seed)
  );

  // Next-state logic for the operation sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SEED;
      SEED: state_d = NR;
      NR:   if (cnt_q == CntW'(NrCyc - 1)) state_d = MUL;
      MUL:  state_d = NORM;
      NORM: state_d = DONE;
      DONE: if (valid_q && ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Shared multiplier: m2*r on t-steps, r*t on r-steps, m1*r in MUL.
  always_comb begin
    mul_a = {1'b0, m2_q, 7'd0};
    mul_b = r_q;
    if (state_q == NR && cnt_q[0]) begin
      mul_a = r_q;
      mul_b = t_q;
    end else if (state_q == MUL) begin
      mul_a = {1'b0, m1_q, 7'd0};
    end
  end

  assign prod     = mul_a * mul_b;
  assign prod_q30 = prod[61:30];

  // Operand capture and iteration datapath; contents only matter once written.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_q <= f1.sign ^ f2.sign;
      e1_q   <= f1.exp;
      e2_q   <= f2.exp;
      m1_q   <= {1'b1, f1.man};
      m2_q   <= {1'b1, f2.man};
    end
    case (state_q)
      SEED: begin
        r_q   <= {2'b00, seed, 20'd0};
        cnt_q <= '0;
      end
      NR: begin
        if (!cnt_q[0]) t_q <= TwoQ - prod_q30;
        else           r_q <= prod_q30;
        cnt_q <= cnt_q + 1'b1;
      end
      MUL: q_q <= prod_q30;
      default: ;
    endcase
  end

  // Normalise q to [1,2), round to nearest, re-normalise on carry.
  always_comb begin
    shift    = ~q_q[30];
    mant_pre = shift ? q_q[29:6] : q_q[30:7];
    rbit     = shift ? q_q[5] : q_q[6];
    mant_rnd = {1'b0, mant_pre} + {24'd0, rbit};
    carry    = mant_rnd[24];
    mant     = carry ? mant_rnd[24:1] : mant_rnd[23:0];
    e_res    = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + $signed(10'(BIAS))
             - $signed({9'd0, shift}) + $signed({9'd0, carry});
  end

`ifdef FDIV_IEEE_SPECIAL_EN
  // NaN/infinity decode; takes priority over the ordinary rules.
  always_comb begin
    spec_hit = 1'b1;
    spec_y   = QNAN;
    spec_ovf = 1'b0;
    if ((e1_q == EXP_INF && |m1_q[22:0]) || (e2_q == EXP_INF && |m2_q[22:0]) ||
        (e1_q == 8'd0 && e2_q == 8'd0) || (e1_q == EXP_INF && e2_q == EXP_INF)) begin
      spec_y = QNAN;
    end else if (e1_q == EXP_INF) begin
      spec_y = pack_inf(sign_q);
    end else if (e2_q == EXP_INF) begin
      spec_y = pack_zero(sign_q);
    end else begin
      spec_hit = 1'b0;
    end
  end
`else
  assign spec_hit = 1'b0;
  assign spec_y   = QNAN;
  assign spec_ovf = 1'b0;
`endif

  // Result selection: special operands, zero divisor/dividend, exponent range.
  always_comb begin
    res_y   = {sign_q, e_res[7:0], mant[22:0]};
    res_ovf = 1'b0;
    if (spec_hit) begin
      res_y   = spec_y;
      res_ovf = spec_ovf;
    end else if (e2_q == 8'd0) begin
      res_y   = pack_inf(sign_q);
      res_ovf = 1'b1;
    end else if (e1_q == 8'd0) begin
      res_y = pack_zero(sign_q);
    end else if (e_res >= 10'sd255) begin
      res_y   = pack_inf(sign_q);
      res_ovf = 1'b1;
    end else if (e_res <= 10'sd0) begin
      res_y = pack_zero(sign_q);
    end
  end

  // Output registers. valid_o follows the result register by one cycle and is
  // held with y/ovf until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (state_q == NORM) begin
        y_q   <= res_y;
        ovf_q <= res_ovf;
      end
      if (state_q == DONE) begin
        if (!valid_q)     valid_q <= 1'b1;
        else if (ready_i) valid_q <= 1'b0;
      end
    end
  end

  // Product bits outside Q2.30, q's sign bit and below-round bits, and the
  // implied leading one are never needed.
  assign unused_bits = ^{prod[63:62], prod[29:0], q_q[31], q_q[4:0], mant[23]};

endmodule
